// File: rtl/adder_serial_cfg.sv
// adder_serial_cfg: digit-serial add/subtract, DIGIT bits per cycle; APPROX_ADDER_EN selects a lower-part OR adder
module adder_serial_cfg #(
  parameter int WIDTH       = 16,
  parameter int DIGIT       = 4,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = NDIG > 1 ? $clog2(NDIG) : 1;
  if (WIDTH % DIGIT != 0 || APPROX_BITS < 1 || APPROX_BITS >= WIDTH) begin : g_bad_params
    $error("adder_serial_cfg: illegal WIDTH/DIGIT/APPROX_BITS");
  end
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t           state_q, state_d, st;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT-1:0] da, db, dsum;
  logic             dcarry;
  assign st        = (state_q == RUN || state_q == DONE) ? state_q : IDLE;
  assign in_ready  = st == IDLE;
  assign out_valid = st == DONE;
  assign busy      = st != IDLE;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign da        = a_q[cnt_q*DIGIT +: DIGIT];
  assign db        = b_q[cnt_q*DIGIT +: DIGIT];
`ifdef APPROX_ADDER_EN
  // Bits below APPROX_BITS use OR for sum and kill the carry, except the top approximate bit, which generates a&b
  always_comb begin
    dcarry = carry_q;
    dsum   = '0;
    for (int j = 0; j < DIGIT; j++) begin
      dsum[j] = (int'(cnt_q)*DIGIT + j < APPROX_BITS) ? da[j] | db[j] : da[j] ^ db[j] ^ dcarry;
      dcarry  = (int'(cnt_q)*DIGIT + j < APPROX_BITS)
                ? ((int'(cnt_q)*DIGIT + j == APPROX_BITS-1) & da[j] & db[j])
                : (da[j] & db[j]) | (dcarry & (da[j] ^ db[j]));
    end
  end
`else
  assign {dcarry, dsum} = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry_q};
`endif
  // Next state: accept operands in IDLE, add one digit per RUN cycle, wait for out_ready in DONE
  always_comb begin
    state_d = st;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    if (st == IDLE && in_valid) begin
      state_d = RUN;
      a_d     = a;
      b_d     = b ^ {WIDTH{sub}};
      carry_d = cin ^ sub;
      cnt_d   = '0;
    end
    if (st == RUN) begin
      sum_d[cnt_q*DIGIT +: DIGIT] = dsum;
      carry_d = dcarry;
      cnt_d   = cnt_q + 1'b1;
      if (cnt_q == CW'(NDIG-1)) begin
        cout_d  = dcarry;
        cnt_d   = '0;
        state_d = DONE;
      end
    end
    if (st == DONE && out_ready) state_d = IDLE;
  end
  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
endmodule

// File: tb/tb_adder_serial_cfg.sv
// tb_adder_serial_cfg: directed and random add/subtract transactions checked against an arithmetic model
module tb_adder_serial_cfg;
  localparam int W  = 16;
  localparam int AB = 4;
  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, cout, busy;
  logic [W-1:0] sum;
  logic [W-1:0] last_sum;
  logic         last_cout;
  int           vectors = 0, miscompares = 0;

  adder_serial_cfg #(.WIDTH(W), .DIGIT(4), .APPROX_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    int unsigned xs, ys, r;
    xs = x;
    ys = s ? {16'h0, ~y} : {16'h0, y};
`ifdef APPROX_ADDER_EN
    r = (((xs >> AB) + (ys >> AB) + ((xs >> (AB-1)) & (ys >> (AB-1)) & 1)) << AB) | ((xs | ys) & ((1 << AB) - 1));
`else
    r = xs + ys + {31'h0, ci ^ s};
`endif
    return r[W:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s,
                     input int hold, input logic poke);
    logic [W:0] e;
    int lat;
    e = model(x, y, ci, s);
    @(negedge clk);
    chk("in_ready before accept", in_ready, 1);
    a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 4);
    chk("sum", sum, e[W-1:0]);
    chk("cout", cout, e[W]);
    chk("busy in done", busy, 1);
    last_sum = sum;
    last_cout = cout;
    for (int i = 0; i < hold; i++) begin
      in_valid = poke;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold sum", sum, last_sum);
      chk("hold cout", cout, last_cout);
      chk("hold out_valid", out_valid, 1);
      chk("hold in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("exit out_valid", out_valid, 0);
    chk("exit in_ready", in_ready, 1);
    chk("exit busy", busy, 0);
    chk("exit sum kept", sum, last_sum);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    chk("reset busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    run(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
`ifndef APPROX_ADDER_EN
    chk("tp1 sum", last_sum, 32'h0100);
    chk("tp1 cout", last_cout, 0);
`endif
    run(16'hFFFF, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
`ifndef APPROX_ADDER_EN
    chk("tp2 sum", last_sum, 32'h0001);
    chk("tp2 cout", last_cout, 1);
`endif
    run(16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0);
`ifndef APPROX_ADDER_EN
    chk("tp3a sum", last_sum, 32'hFFFE);
    chk("tp3a cout", last_cout, 0);
`endif
    run(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0);
`ifndef APPROX_ADDER_EN
    chk("tp3b sum", last_sum, 32'h0002);
    chk("tp3b cout", last_cout, 1);
`endif
    run(16'h1234, 16'h4321, 1'b0, 1'b0, 3, 1'b1);
    @(negedge clk);
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid-run busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset sum", sum, 0);
    chk("async reset cout", cout, 0);
    chk("async reset busy", busy, 0);
    chk("async reset in_ready", in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    run(16'h8001, 16'h7FFF, 1'b0, 1'b0, 1, 1'b0);
    run(16'h000F, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
`ifdef APPROX_ADDER_EN
    chk("tp6 sum", last_sum, 32'h000F);
`else
    chk("tp6 sum", last_sum, 32'h0011);
`endif
    chk("tp6 cout", last_cout, 0);
    for (int k = 0; k < 40; k++)
      run(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
